// File: rtl/vga_scan_controller_if.sv
// Raster/pixel bundle between the scan controller, the game top that renders
// from x/y, and the board DAC.
interface vga_scan_controller_if;
  logic [11:0] rgb_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        pixel_tick;
  logic        line_tick;
  logic        frame_tick;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb_out;

  // Free-running raster with no valid/ready pair: every pixel_tick is a transfer
  // that nobody can stall, so rgb_in must settle within one pixel slot of x/y.
  modport master (
    input  rgb_in,
    output x, y, pixel_tick, line_tick, frame_tick,
    output video_on, hsync, vsync, rgb_out
  );

  modport slave (
    output rgb_in,
    input  x, y, pixel_tick, line_tick, frame_tick,
    input  video_on, hsync, vsync, rgb_out
  );
endinterface

// File: rtl/vga_scan_controller.sv
// VGA raster timing: pixel divider, h/v scan counters and a one-slot output
// register that blanks the game pixel and keeps colour and sync aligned.
module vga_scan_controller #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int CLK_DIV     = 2,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  vga_scan_controller_if.master  bus
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [2:0] DIV_LAST     = 3'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS        = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [2:0]  div_cnt;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        pixel_tick;
  logic        line_end;
  logic        frame_end;
  logic        vis_c;
  logic        hs_c;
  logic        vs_c;
  logic        video_on_q;
  logic        hsync_q;
  logic        vsync_q;
  logic [11:0] rgb_q;

  // Gating with reset keeps the strobe low while held in reset even when
  // CLK_DIV=1, where div_cnt==DIV_LAST is always true.
  assign pixel_tick = (div_cnt == DIV_LAST) && !reset;
  assign line_end   = pixel_tick && (h_cnt == H_LAST);
  assign frame_end  = line_end && (v_cnt == V_LAST);

  assign vis_c = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_c  = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
  assign vs_c  = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (pixel_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pixel_tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Loaded on the last clk of each slot, so rgb_in gets CLK_DIV-1 clks to settle
  // and every output trails x/y by exactly one slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      video_on_q <= 1'b0;
      rgb_q      <= '0;
      hsync_q    <= ~SYNC_ACTIVE;
      vsync_q    <= ~SYNC_ACTIVE;
    end else if (pixel_tick) begin
      video_on_q <= vis_c;
      rgb_q      <= vis_c ? bus.rgb_in : 12'h000;
      hsync_q    <= hs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_q    <= vs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  assign bus.x          = h_cnt;
  assign bus.y          = v_cnt;
  assign bus.pixel_tick = pixel_tick;
  assign bus.line_tick  = line_end;
  assign bus.frame_tick = frame_end;
  assign bus.video_on   = video_on_q;
  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.rgb_out    = rgb_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench for vga_scan_controller on a shrunken raster (15x11 slots,
// CLK_DIV=2) so whole frames fit in a few hundred clocks.
module tb_vga_scan_controller;

  localparam int HD = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VD = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int DIV = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int LINE_CLKS  = HT * DIV;
  localparam int FRAME_CLKS = HT * VT * DIV;
  localparam int BOUND      = 2 * FRAME_CLKS + 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          mode = 0;
  logic [11:0] rgb_const = 12'h000;
  logic [11:0] exp_q[$];

  vga_scan_controller_if bus();

  // Game model: constant colour, or its own x coordinate as colour.
  assign bus.rgb_in = (mode == 1) ? {2'b00, bus.x} : rgb_const;

  vga_scan_controller #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(DIV), .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #(BOUND * 100);
    $display("FAIL watchdog: simulation exceeded %0d time units", BOUND * 100);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) step();
    checks++; if (bus.x !== 10'd0) begin errors++; $display("FAIL reset_x got %0d want 0", bus.x); end
    checks++; if (bus.y !== 10'd0) begin errors++; $display("FAIL reset_y got %0d want 0", bus.y); end
    checks++; if (bus.rgb_out !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", bus.rgb_out); end
    checks++; if (bus.video_on !== 1'b0) begin errors++; $display("FAIL reset_video_on got %b want 0", bus.video_on); end
    checks++; if ({bus.hsync, bus.vsync} !== 2'b11) begin errors++; $display("FAIL reset_syncs got %b%b want 11", bus.hsync, bus.vsync); end
    checks++;
    if ({bus.pixel_tick, bus.line_tick, bus.frame_tick} !== 3'b000) begin
      errors++; $display("FAIL reset_ticks got %b%b%b want 000", bus.pixel_tick, bus.line_tick, bus.frame_tick);
    end
    reset = 1'b0;
    #1;
    checks++; if (bus.pixel_tick !== 1'b0) begin errors++; $display("FAIL release_tick got %b want 0", bus.pixel_tick); end
    n = 0;
    while (bus.pixel_tick !== 1'b1 && n < 16) begin step(); n++; end
    // The first slot's strobe is high in its last clk, consumed at clk DIV.
    checks++; if (n != DIV - 1) begin errors++; $display("FAIL first_pixel_tick got %0d clks want %0d", n, DIV - 1); end
    checks++; if (bus.x !== 10'd0) begin errors++; $display("FAIL first_tick_x got %0d want 0", bus.x); end
    step();
    checks++; if (bus.x !== 10'd1 || bus.pixel_tick !== 1'b0) begin
      errors++; $display("FAIL after_first_tick got x=%0d tick=%b want x=1 tick=0", bus.x, bus.pixel_tick);
    end
  endtask

  task automatic test_horizontal();
    int n;
    n = 0;
    while (bus.line_tick !== 1'b1 && n < BOUND) begin step(); n++; end
    checks++; if (bus.line_tick !== 1'b1) begin errors++; $display("FAIL line_tick_seen got 0 want 1"); end
    step(); n = 1;
    while (bus.line_tick !== 1'b1 && n < BOUND) begin step(); n++; end
    checks++; if (n != LINE_CLKS) begin errors++; $display("FAIL line_period got %0d want %0d", n, LINE_CLKS); end
    n = 0;
    while (bus.x === 10'(HD + HF) && n < BOUND) begin step(); n++; end
    n = 0;
    while (bus.x !== 10'(HD + HF) && n < BOUND) begin step(); n++; end
    checks++; if (bus.hsync !== 1'b1) begin errors++; $display("FAIL hsync_before got %b want 1", bus.hsync); end
    n = 0;
    while (bus.hsync !== 1'b0 && n < BOUND) begin step(); n++; end
    checks++; if (n != DIV) begin errors++; $display("FAIL hsync_delay got %0d want %0d", n, DIV); end
    n = 0;
    while (bus.hsync === 1'b0 && n < BOUND) begin step(); n++; end
    checks++; if (n != HS * DIV) begin errors++; $display("FAIL hsync_width got %0d want %0d", n, HS * DIV); end
    checks++; if (bus.x !== 10'(HD + HF + HS + 1)) begin
      errors++; $display("FAIL hsync_end_x got %0d want %0d", bus.x, HD + HF + HS + 1);
    end
  endtask

  task automatic test_vertical();
    int n;
    n = 0;
    while (bus.frame_tick !== 1'b1 && n < BOUND) begin step(); n++; end
    checks++; if (bus.x !== 10'(HT - 1) || bus.y !== 10'(VT - 1)) begin
      errors++; $display("FAIL frame_end_xy got %0d,%0d want %0d,%0d", bus.x, bus.y, HT - 1, VT - 1);
    end
    step();
    checks++; if (bus.x !== 10'd0 || bus.y !== 10'd0) begin
      errors++; $display("FAIL frame_wrap_xy got %0d,%0d want 0,0", bus.x, bus.y);
    end
    n = 1;
    while (bus.frame_tick !== 1'b1 && n < BOUND) begin step(); n++; end
    checks++; if (n != FRAME_CLKS) begin errors++; $display("FAIL frame_period got %0d want %0d", n, FRAME_CLKS); end
    n = 0;
    while (!(bus.y === 10'(VD + VF) && bus.x === 10'd0) && n < BOUND) begin step(); n++; end
    checks++; if (bus.vsync !== 1'b1) begin errors++; $display("FAIL vsync_before got %b want 1", bus.vsync); end
    n = 0;
    while (bus.vsync !== 1'b0 && n < BOUND) begin step(); n++; end
    checks++; if (n != DIV) begin errors++; $display("FAIL vsync_delay got %0d want %0d", n, DIV); end
    n = 0;
    while (bus.vsync === 1'b0 && n < BOUND) begin step(); n++; end
    checks++; if (n != VS * LINE_CLKS) begin errors++; $display("FAIL vsync_width got %0d want %0d", n, VS * LINE_CLKS); end
  endtask

  task automatic test_blanking();
    int n, px, py, lit, slots;
    logic exp_vis;
    mode = 0;
    rgb_const = 12'hE22;
    n = 0;
    while (bus.frame_tick !== 1'b1 && n < BOUND) begin step(); n++; end
    px = int'(bus.x); py = int'(bus.y);
    lit = 0; slots = 0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      step();
      if (bus.pixel_tick === 1'b1) begin
        slots++;
        exp_vis = (px < HD) && (py < VD);
        checks++; if (bus.video_on !== exp_vis) begin
          errors++; $display("FAIL blank_video_on slot %0d,%0d got %b want %b", px, py, bus.video_on, exp_vis);
        end
        checks++; if (bus.rgb_out !== (exp_vis ? 12'hE22 : 12'h000)) begin
          errors++; $display("FAIL blank_rgb slot %0d,%0d got %h want %h", px, py, bus.rgb_out, exp_vis ? 12'hE22 : 12'h000);
        end
        if (bus.rgb_out === 12'hE22) lit++;
        px = int'(bus.x); py = int'(bus.y);
      end
    end
    checks++; if (slots != HT * VT) begin errors++; $display("FAIL blank_slots got %0d want %0d", slots, HT * VT); end
    checks++; if (lit != HD * VD) begin errors++; $display("FAIL blank_lit got %0d want %0d", lit, HD * VD); end
  endtask

  task automatic test_alignment();
    int n;
    logic [11:0] exp_rgb;
    mode = 1;
    exp_q.delete();
    n = 0;
    while (bus.frame_tick !== 1'b1 && n < BOUND) begin step(); n++; end
    exp_q.push_back(12'h000);
    for (int i = 0; i < FRAME_CLKS; i++) begin
      step();
      if (bus.pixel_tick === 1'b1) begin
        exp_rgb = exp_q.pop_front();
        checks++; if (bus.rgb_out !== exp_rgb) begin
          errors++; $display("FAIL align_rgb at x=%0d y=%0d got %h want %h", bus.x, bus.y, bus.rgb_out, exp_rgb);
        end
        exp_q.push_back((int'(bus.x) < HD && int'(bus.y) < VD) ? {2'b00, bus.x} : 12'h000);
      end
    end
    checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL align_queue got %0d want 1", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    mode = 1;
    n = 0;
    while (!(bus.x === 10'd5 && bus.y === 10'd3) && n < BOUND) begin step(); n++; end
    checks++; if (bus.rgb_out !== 12'h004) begin errors++; $display("FAIL mid_pre_rgb got %h want 004", bus.rgb_out); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.x !== 10'd0 || bus.y !== 10'd0) begin
      errors++; $display("FAIL mid_async_xy got %0d,%0d want 0,0", bus.x, bus.y);
    end
    checks++; if (bus.rgb_out !== 12'h000 || bus.video_on !== 1'b0) begin
      errors++; $display("FAIL mid_async_rgb got %h/%b want 000/0", bus.rgb_out, bus.video_on);
    end
    step();
    reset = 1'b0;
    n = 0;
    while (bus.frame_tick !== 1'b1 && n < BOUND) begin step(); n++; end
    checks++; if (n != FRAME_CLKS - 1) begin errors++; $display("FAIL mid_frame_tick got %0d want %0d", n, FRAME_CLKS - 1); end
    n = 0;
    while (!(bus.hsync === 1'b0 && bus.vsync === 1'b0) && n < BOUND) begin step(); n++; end
    checks++; if ({bus.hsync, bus.vsync} !== 2'b00) begin errors++; $display("FAIL mid_syncs_low got %b%b want 00", bus.hsync, bus.vsync); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({bus.hsync, bus.vsync} !== 2'b11) begin
      errors++; $display("FAIL mid_async_syncs got %b%b want 11", bus.hsync, bus.vsync);
    end
    step();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_blanking();
    test_alignment();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
Raster timing stage that sits directly upstream and downstream of a game top. It generates the x/y scan coordinates the game's shaders and renderers consume. It registers the game's 12-bit `out` pixel, blanks it outside the visible area and drives it to the board DAC. HSYNC and VSYNC are pipelined so that colour and sync leave the block aligned.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- CLK_DIV, 2, clk cycles per pixel slot (50 MHz -> 25 MHz); legal values are 1..8
- SYNC_ACTIVE, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- rgb_in  in  12  pixel from game, RGB order, combinational function of x,y
- x  out  10  current horizontal count h_cnt, 0..H_TOTAL-1
- y  out  10  current vertical count v_cnt, 0..V_TOTAL-1
- pixel_tick  out  1  one-clk strobe, high when div_cnt==CLK_DIV-1
- line_tick  out  1  pixel_tick AND h_cnt==H_TOTAL-1
- frame_tick  out  1  line_tick AND v_cnt==V_TOTAL-1
- video_on  out  1  registered visible-area flag, aligned with rgb_out
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- rgb_out  out  12  registered, blanked pixel to DAC

Behaviour:
- Derived constants: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Clock and reset: one clock domain; reset is asynchronous and active-high; all registers use posedge clk, posedge reset.
- Reset values:
  - div_cnt, h_cnt, v_cnt = 0, so x = 0 and y = 0.
  - pixel_tick, line_tick, frame_tick = 0.
  - video_on = 0, rgb_out = 12'h000.
  - hsync = vsync = ~SYNC_ACTIVE (inactive).
- Reset mid-frame: counters return to 0 immediately (asynchronously); the first pixel_tick after release occurs at clk CLK_DIV.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - With CLK_DIV=1, pixel_tick is constant 1 after reset release.
- Horizontal counter: on pixel_tick, h_cnt increments; it wraps H_TOTAL-1 -> 0.
- Vertical counter:
  - On the h_cnt wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - h_cnt and v_cnt wrap in the same clk at the frame end.
- Tick strobes: pixel_tick, line_tick and frame_tick are combinational from the counters and are exactly one clk wide.
- Combinational (pre-pipeline) terms:
  - vis_c = (h_cnt < H_DISPLAY) AND (v_cnt < V_DISPLAY).
  - hs_c is active for H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vs_c is active for V_DISPLAY+V_FRONT <= v_cnt < V_DISPLAY+V_FRONT+V_SYNC (490..491).
- Output pipeline: one register stage, loaded only on pixel_tick:
  - video_on <= vis_c.
  - rgb_out <= vis_c ? rgb_in : 0.
  - hsync <= hs_c ? SYNC_ACTIVE : ~SYNC_ACTIVE; vsync likewise.
  - Between ticks the register outputs hold their value.
- Latency:
  - Colour, sync and video_on lag the x/y coordinates by exactly one pixel slot (CLK_DIV clks).
  - rgb_in is sampled on the final clk of its slot, giving the game CLK_DIV-1 clks of settling.
- Blanking: rgb_out is never non-zero while video_on = 0, whatever rgb_in is.
- x/y range: x and y are not clamped. Consumers must gate on coordinates below H_DISPLAY/V_DISPLAY; 10 bits covers 0..799 and 0..524.
- No handshake and no backpressure: the raster is free-running. The game must tolerate any rgb_in latency shorter than one slot.

Test Plan:
- Reset behaviour: assert reset for 3 clks, then release.
  - Required: x = 0, y = 0, rgb_out = 0, hsync = vsync = 1 and ticks = 0 during reset.
  - Required: first pixel_tick at clk 2 after release.
- Horizontal timing: run 2 lines with default parameters.
  - Required: line_tick period is 1600 clks.
  - Required: hsync goes low one slot after h_cnt = 656, stays low for 96 slots (192 clks), then goes high again.
- Vertical timing: run 2 frames.
  - Required: frame_tick period is 840000 clks, and vsync is low for exactly 2 lines (3200 clks) starting one slot after (v = 490, h = 0).
  - Required: the counters wrap from x = 799, y = 524 to x = 0, y = 0 in the same clk.
- Blanking: hold rgb_in = 12'hE22 constantly.
  - Required: rgb_out = E22 only while video_on = 1, giving 640x480 lit slots per frame.
  - Required: rgb_out = 000 at h_cnt 640..799 and at v_cnt 480..524.
- Alignment: drive rgb_in = {2'b0, x} (12 bits).
  - Required: in each visible slot, rgb_out equals the previous slot's x value, i.e. a latency of one slot.
- Reset mid-frame: assert reset at x = 300, y = 200 for 1 clk.
  - Required: the counters return to 0 asynchronously, and rgb_out and the syncs return to their reset values.
  - Required: the next frame_tick arrives 840000 clks after release.
